// File: rtl/inst_package.sv
// Shared constants and types for the sub-core dispatcher.
package inst_package;

  localparam int N_SUB_DEFAULT  = 4;
  localparam int QDEPTH_DEFAULT = 4;

  // Per-sub tracker states.
  typedef enum logic [1:0] {
    SUB_IDLE   = 2'd0,
    SUB_LAUNCH = 2'd1,
    SUB_RUN    = 2'd2
  } sub_state_t;

endpackage

// File: rtl/sub_dispatch_if.sv
// Main-core / sub-core side bundle of the dispatcher. The master modport is the
// environment (main core plus sub cores); the slave modport is the dispatcher.
interface sub_dispatch_if
  import inst_package::*;
#(
  parameter int N_SUB = N_SUB_DEFAULT
) ();

  logic                     req_valid;
  logic [31:0]              req_pc;
  logic                     req_ready;
  logic [N_SUB-1:0]         sub_ended;
  logic [N_SUB-1:0]         exec_requested;
  logic [31:0]              requested_pc;
  logic                     join_req;
  logic                     join_done;
  logic [N_SUB-1:0]         busy;
  logic [$clog2(N_SUB):0]   n_active;

  modport master (
    output req_valid, req_pc, sub_ended, join_req,
    input  req_ready, exec_requested, requested_pc, join_done, busy, n_active
  );

  modport slave (
    input  req_valid, req_pc, sub_ended, join_req,
    output req_ready, exec_requested, requested_pc, join_done, busy, n_active
  );

endinterface

// File: rtl/pc_fifo.sv
// Pending-PC queue: synchronous FIFO, one push and one pop per cycle,
// registered full/empty flags, head visible combinationally.
module pc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Next occupancy, used to register the full/empty flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and flags; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == FULL_COUNT);
      empty <= (count_nxt == '0);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read after being written, gated by empty.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sub_dispatch.sv
// Dispatches queued task PCs from the main core to idle sub cores in
// round-robin order, tracks each sub's lifecycle and services join barriers.
module sub_dispatch
  import inst_package::*;
#(
  parameter int N_SUB  = N_SUB_DEFAULT,
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  sub_dispatch_if.slave bus
);

  localparam int IW = (N_SUB > 1) ? $clog2(N_SUB) : 1;
  localparam int CW = $clog2(N_SUB) + 1;
  localparam logic [IW:0] N_SUB_W = (IW+1)'(N_SUB);

  sub_state_t       state     [N_SUB];
  sub_state_t       state_nxt [N_SUB];
  logic [N_SUB-1:0] idle;
  logic [N_SUB-1:0] grant;
  logic [N_SUB-1:0] busy_nxt;
  logic [N_SUB-1:0] busy_q;
  logic [CW-1:0]    active_nxt;
  logic [CW-1:0]    n_active_q;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    grant_idx;
  logic [IW:0]      cand;
  logic             found;
  logic             push;
  logic             dispatch;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      head;
  logic [31:0]      last_pc;
  logic             join_pending;

  assign push = bus.req_valid && !fifo_full;

  pc_fifo #(.DEPTH(QDEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.req_pc),
    .pop       (dispatch),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Round-robin pick: lowest idle index strictly after the last grant, wrapping.
  always_comb begin
    idle      = '0;
    found     = 1'b0;
    grant_idx = last_grant;
    cand      = '0;
    for (int i = 0; i < N_SUB; i++) idle[i] = (state[i] == SUB_IDLE);
    for (int k = 1; k <= N_SUB; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= N_SUB_W) cand = cand - N_SUB_W;
      if (!found && idle[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  // A registered empty flag means a PC pushed this cycle cannot dispatch until the next.
  assign dispatch = !fifo_empty && found;

  // One-hot start pulse for the chosen sub.
  always_comb begin
    grant = '0;
    if (dispatch) grant[grant_idx] = 1'b1;
  end

  // Tracker next state; LAUNCH waits for ended to drop so a stale ended=1 is absorbed.
  always_comb begin
    active_nxt = '0;
    for (int i = 0; i < N_SUB; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        SUB_IDLE:   if (grant[i])         state_nxt[i] = SUB_LAUNCH;
        SUB_LAUNCH: if (!bus.sub_ended[i]) state_nxt[i] = SUB_RUN;
        SUB_RUN:    if (bus.sub_ended[i])  state_nxt[i] = SUB_IDLE;
        default:                          state_nxt[i] = SUB_IDLE;
      endcase
      busy_nxt[i] = (state_nxt[i] != SUB_IDLE);
      active_nxt  = active_nxt + CW'(busy_nxt[i]);
    end
  end

  // Tracker state with registered busy vector and active count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SUB; i++) state[i] <= SUB_IDLE;
      busy_q     <= '0;
      n_active_q <= '0;
    end else begin
      for (int i = 0; i < N_SUB; i++) state[i] <= state_nxt[i];
      busy_q     <= busy_nxt;
      n_active_q <= active_nxt;
    end
  end

  // Last grant index and the PC held on the shared bus between dispatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(N_SUB - 1);
      last_pc    <= '0;
    end else if (dispatch) begin
      last_grant <= grant_idx;
      last_pc    <= head;
    end
  end

  // Join barrier: pending until everything has drained, then one pulse.
  always_ff @(posedge clk) begin
    if (rst)               join_pending <= 1'b0;
    else if (bus.join_done) join_pending <= 1'b0;
    else if (bus.join_req)  join_pending <= 1'b1;
  end

  assign bus.join_done      = join_pending && fifo_empty && !push && (&idle);
  assign bus.req_ready      = !fifo_full;
  assign bus.exec_requested = grant;
  assign bus.requested_pc   = dispatch ? head : last_pc;
  assign bus.busy           = busy_q;
  assign bus.n_active       = n_active_q;

endmodule

// File: tb/tb_sub_dispatch.sv
// Directed self-checking bench for sub_dispatch (N_SUB=4, QDEPTH=4).
module tb_sub_dispatch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sub_dispatch_if bus ();

  sub_dispatch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.sub_ended = '0;
    bus.join_req  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset values
    do_reset();
    #1;
    check("rst_busy",      bus.busy, 0);
    check("rst_n_active",  bus.n_active, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_exec",      bus.exec_requested, 0);
    check("rst_pc",        bus.requested_pc, 0);
    check("rst_join_done", bus.join_done, 0);

    // Single push: dispatch the next cycle to sub 0
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h100;
    #1;
    check("single_no_bypass", bus.exec_requested, 0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("single_exec", bus.exec_requested, 4'b0001);
    check("single_pc",   bus.requested_pc, 32'h100);
    check("single_busy_before_edge", bus.busy, 0);
    tick();
    #1;
    check("single_busy_after",  bus.busy, 4'b0001);
    check("single_n_active",    bus.n_active, 1);
    check("single_exec_pulse",  bus.exec_requested, 0);
    check("single_pc_hold",     bus.requested_pc, 32'h100);
    tick();
    bus.sub_ended = 4'b0001;
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("single_end_busy", bus.busy, 0);
    check("single_end_n_active", bus.n_active, 0);

    // Round robin over five PCs; the fifth waits for sub 2 to end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h10 * (k + 1);
      #1;
      if (k == 0) begin
        check("rr_first_no_dispatch", bus.exec_requested, 0);
      end else begin
        check("rr_exec", bus.exec_requested, 32'(1 << (k - 1)));
        check("rr_pc",   bus.requested_pc, 32'h10 * k);
      end
      tick();
    end
    bus.req_valid = 1'b0;
    #1;
    check("rr_wait_exec",     bus.exec_requested, 0);
    check("rr_all_busy",      bus.busy, 4'b1111);
    check("rr_n_active_4",    bus.n_active, 4);
    check("rr_pc_hold",       bus.requested_pc, 32'h40);
    tick();
    bus.sub_ended = 4'b0100;
    #1;
    check("rr_end_cycle_exec", bus.exec_requested, 0);
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("rr_fifth_exec", bus.exec_requested, 4'b0100);
    check("rr_fifth_pc",   bus.requested_pc, 32'h50);
    check("rr_fifth_busy", bus.busy, 4'b1011);
    tick();
    #1;
    check("rr_refilled_busy", bus.busy, 4'b1111);
    check("rr_refilled_exec", bus.exec_requested, 0);

    // Stale ended flag on sub 2 is absorbed by LAUNCH
    do_reset();
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'hA0;
    tick();
    bus.req_pc = 32'hA4;
    #1;
    check("stale_exec0", bus.exec_requested, 4'b0001);
    tick();
    bus.req_pc = 32'hA8;
    #1;
    check("stale_exec1", bus.exec_requested, 4'b0010);
    tick();
    bus.req_valid = 1'b0;
    bus.sub_ended = 4'b0100;
    #1;
    check("stale_exec2", bus.exec_requested, 4'b0100);
    check("stale_pc2",   bus.requested_pc, 32'hA8);
    tick();
    #1;
    check("stale_busy_launch", bus.busy, 4'b0111);
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("stale_busy_absorbed", bus.busy, 4'b0111);
    for (int k = 0; k < 10; k++) tick();
    #1;
    check("stale_busy_running", bus.busy, 4'b0111);
    bus.sub_ended = 4'b0100;
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("stale_busy_ended", bus.busy, 4'b0011);

    // Join with subs 0 and 1 running, empty queue
    bus.join_req = 1'b1;
    #1;
    check("join_req_cycle", bus.join_done, 0);
    tick();
    bus.join_req = 1'b0;
    #1;
    check("join_pending_busy", bus.join_done, 0);
    bus.sub_ended = 4'b0001;
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("join_one_left", bus.join_done, 0);
    check("join_n_active_1", bus.n_active, 1);
    bus.sub_ended = 4'b0010;
    #1;
    check("join_last_ending", bus.join_done, 0);
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("join_pulse", bus.join_done, 1);
    check("join_n_active_0", bus.n_active, 0);
    tick();
    #1;
    check("join_pulse_one_cycle", bus.join_done, 0);
    bus.join_req = 1'b1;
    #1;
    check("join_idle_req_cycle", bus.join_done, 0);
    tick();
    bus.join_req = 1'b0;
    #1;
    check("join_idle_next_cycle", bus.join_done, 1);
    tick();
    #1;
    check("join_idle_cleared", bus.join_done, 0);

    // Full queue back-pressure
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h400 + 32'(4 * k);
      tick();
    end
    bus.req_pc = 32'h420;
    #1;
    check("full_ready_low",  bus.req_ready, 0);
    check("full_no_dispatch", bus.exec_requested, 0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("full_still_low", bus.req_ready, 0);
    bus.sub_ended = 4'b0010;
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("full_pop_exec",   bus.exec_requested, 4'b0010);
    check("full_pop_pc",     bus.requested_pc, 32'h410);
    check("full_pop_ready",  bus.req_ready, 0);
    tick();
    #1;
    check("full_ready_back", bus.req_ready, 1);
    check("full_exec_idle",  bus.exec_requested, 0);
    bus.sub_ended = 4'b1101;
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("drain_exec_a", bus.exec_requested, 4'b0100);
    check("drain_pc_a",   bus.requested_pc, 32'h414);
    tick();
    #1;
    check("drain_exec_b", bus.exec_requested, 4'b1000);
    check("drain_pc_b",   bus.requested_pc, 32'h418);
    tick();
    #1;
    check("drain_exec_c", bus.exec_requested, 4'b0001);
    check("drain_pc_c",   bus.requested_pc, 32'h41C);
    tick();
    #1;
    check("drain_empty_exec", bus.exec_requested, 0);
    check("drain_pc_hold",    bus.requested_pc, 32'h41C);
    check("drain_n_active",   bus.n_active, 4);

    // Reset mid-task with three subs busy and PCs queued
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h500;
    tick();
    bus.req_pc = 32'h504;
    tick();
    bus.req_valid = 1'b0;
    bus.sub_ended = 4'b0010;
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("mid_n_active_3", bus.n_active, 3);
    check("mid_exec",       bus.exec_requested, 4'b0010);
    check("mid_pc",         bus.requested_pc, 32'h500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy",     bus.busy, 0);
    check("mid_rst_n_active", bus.n_active, 0);
    check("mid_rst_ready",    bus.req_ready, 1);
    check("mid_rst_exec",     bus.exec_requested, 0);
    check("mid_rst_pc",       bus.requested_pc, 0);
    bus.sub_ended = 4'b1111;
    tick();
    bus.sub_ended = 4'b0000;
    #1;
    check("mid_ended_busy",     bus.busy, 0);
    check("mid_ended_n_active", bus.n_active, 0);
    check("mid_ended_exec",     bus.exec_requested, 0);
    tick();
    #1;
    check("mid_quiet_busy", bus.busy, 0);
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h600;
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("mid_rr_restart_exec", bus.exec_requested, 4'b0001);
    check("mid_rr_restart_pc",   bus.requested_pc, 32'h600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
